// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: start/run/halt control with relative branches,
// absolute jumps, stall hold and a saturating retired-instruction counter.
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             Zero,
  input  logic             Done,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             JumpEn,
  input  logic [OFF_W-1:0] Offset,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             FetchEn,
  output logic             Running,
  output logic             HaltPulse,
  output logic [CNT_W-1:0] InstrCount
);

  // state  | meaning
  // IDLE   | after reset, PC parked at 0, waiting for start
  // RUN    | issuing instructions, PC advancing
  // HALTED | Done seen, PC and count frozen until start
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t                  state;
  logic signed [OFF_W-1:0] offset_s;
  logic [PC_W-1:0]         offset_ext;
  logic [PC_W-1:0]         pc_next;

  // Sized cast of a signed operand sign-extends (or truncates) to PC_W.
  assign offset_s   = Offset;
  assign offset_ext = PC_W'(offset_s);

  always_comb begin
    pc_next = PC + PC_W'(1);
    if (JumpEn)
      pc_next = Target;
    else if (BranchEn && Zero)
      pc_next = PC + offset_ext;
  end

  assign FetchEn = Running & ~Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      PC         <= '0;
      InstrCount <= '0;
      Running    <= 1'b0;
      HaltPulse  <= 1'b0;
    end else begin
      HaltPulse <= 1'b0;
      // start wins in every state, including a restart mid-RUN.
      if (start) begin
        state      <= RUN;
        PC         <= '0;
        InstrCount <= '0;
        Running    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            PC      <= '0;
            Running <= 1'b0;
          end
          RUN: begin
            if (Done) begin
              state     <= HALTED;
              Running   <= 1'b0;
              HaltPulse <= 1'b1;
            end else if (!Stall) begin
              PC <= pc_next;
              if (InstrCount != '1)
                InstrCount <= InstrCount + CNT_W'(1);
            end
          end
          HALTED: begin
            Running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            PC      <= '0;
            Running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: an abstract model checked every cycle
// plus literal expectations at the notable points of the sequence.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0, Zero = 1'b0, Done = 1'b0, Stall = 1'b0;
  logic        BranchEn = 1'b0, JumpEn = 1'b0;
  logic [7:0]  Offset = '0;
  logic [9:0]  Target = '0;

  logic [9:0]  pc, pc4;
  logic        fetch_en, fetch_en4, running, running4, halt_pulse, halt_pulse4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .Zero(Zero), .Done(Done),
    .Stall(Stall), .BranchEn(BranchEn), .JumpEn(JumpEn), .Offset(Offset),
    .Target(Target), .PC(pc), .FetchEn(fetch_en), .Running(running),
    .HaltPulse(halt_pulse), .InstrCount(instr_count)
  );

  fetch_sequencer #(.CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .start(start), .Zero(Zero), .Done(Done),
    .Stall(Stall), .BranchEn(BranchEn), .JumpEn(JumpEn), .Offset(Offset),
    .Target(Target), .PC(pc4), .FetchEn(fetch_en4), .Running(running4),
    .HaltPulse(halt_pulse4), .InstrCount(instr_count4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode = 0;
  int m_pc = 0;
  int m_cnt = 0;
  int m_cnt4 = 0;
  int m_pulse = 0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (start) begin
        m_mode = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
      end else if (m_mode == 1) begin
        if (Done) begin
          m_mode = 2;
          m_pulse = 1;
        end else if (!Stall) begin
          if (JumpEn)                m_pc = int'(Target);
          else if (BranchEn && Zero) m_pc = (m_pc + int'($signed(Offset))) % 1024;
          else                       m_pc = (m_pc + 1) % 1024;
          if (m_pc < 0) m_pc += 1024;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end
    end
  end

  always @(posedge Clk) begin
    #2;
    chk("pc", int'(pc), m_pc);
    chk("pc4", int'(pc4), m_pc);
    chk("running", int'(running), int'(m_mode == 1));
    chk("running4", int'(running4), int'(m_mode == 1));
    chk("fetch_en", int'(fetch_en), int'(m_mode == 1 && !Stall));
    chk("fetch_en4", int'(fetch_en4), int'(m_mode == 1 && !Stall));
    chk("halt_pulse", int'(halt_pulse), m_pulse);
    chk("halt_pulse4", int'(halt_pulse4), m_pulse);
    chk("instr_count", int'(instr_count), m_cnt);
    chk("instr_count4", int'(instr_count4), m_cnt4);
  end

  task automatic step();
    @(posedge Clk);
    #3;
  endtask

  task automatic clr();
    start = 0; Zero = 0; Done = 0; Stall = 0; BranchEn = 0; JumpEn = 0;
    Offset = '0; Target = '0;
  endtask

  task automatic jump_to(input logic [9:0] t);
    clr(); JumpEn = 1; Target = t; step(); clr();
  endtask

  initial begin
    step(); step();
    chk("lit_reset_pc", int'(pc), 0);
    chk("lit_reset_run", int'(running), 0);
    chk("lit_reset_cnt", int'(instr_count), 0);
    Reset = 1;
    // Idle ignores Done and branch inputs and does not move without start.
    Done = 1; BranchEn = 1; JumpEn = 1; Zero = 1; Target = 10'h055;
    step();
    chk("lit_idle_pc", int'(pc), 0);
    chk("lit_idle_run", int'(running), 0);
    clr();

    start = 1; step(); start = 0;
    chk("lit_start_pc", int'(pc), 0);
    chk("lit_start_run", int'(running), 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("lit_seq_pc", int'(pc), i);
    end
    chk("lit_seq_cnt", int'(instr_count), 5);
    chk("lit_seq_run", int'(running), 1);

    jump_to(10'h010);
    BranchEn = 1; Zero = 1; Offset = 8'hFC; step();
    chk("lit_br_taken", int'(pc), 'h00C);
    jump_to(10'h010);
    BranchEn = 1; Zero = 0; Offset = 8'hFC; step();
    chk("lit_br_not_taken", int'(pc), 'h011);

    jump_to(10'h3FF);
    step();
    chk("lit_wrap_up", int'(pc), 'h000);
    JumpEn = 1; BranchEn = 1; Zero = 1; Offset = 8'h05; Target = 10'h123; step();
    chk("lit_jump_prio", int'(pc), 'h123);
    jump_to(10'h002);
    BranchEn = 1; Zero = 1; Offset = 8'hFC; step();
    chk("lit_wrap_down", int'(pc), 'h3FE);
    clr(); BranchEn = 1; Zero = 1; Offset = 8'h7F; step();
    chk("lit_br_max", int'(pc), 'h07D);

    clr(); Stall = 1; JumpEn = 1; Target = 10'h200; step(); step();
    chk("lit_stall_pc", int'(pc), 'h07D);

    clr(); Done = 1; Stall = 1; JumpEn = 1; Target = 10'h111; step();
    chk("lit_halt_pc", int'(pc), 'h07D);
    chk("lit_halt_pulse", int'(halt_pulse), 1);
    chk("lit_halt_run", int'(running), 0);
    clr(); step();
    chk("lit_halt_pulse_end", int'(halt_pulse), 0);
    chk("lit_halt_fetch", int'(fetch_en), 0);
    Done = 1; step(); clr();

    start = 1; step(); clr();
    chk("lit_restart_pc", int'(pc), 0);
    chk("lit_restart_cnt", int'(instr_count), 0);
    chk("lit_restart_run", int'(running), 1);
    jump_to(10'h050);
    start = 1; Done = 1; Stall = 1; JumpEn = 1; Target = 10'h3AA; step(); clr();
    chk("lit_run_restart_pc", int'(pc), 0);
    chk("lit_run_restart_run", int'(running), 1);

    // Done in the cycle right after start must halt.
    Done = 1; step(); clr();
    chk("lit_done_after_start", int'(running), 0);
    chk("lit_done_after_start_pulse", int'(halt_pulse), 1);

    start = 1; step(); clr();
    for (int i = 0; i < 20; i++) step();
    chk("lit_cnt4_sat", int'(instr_count4), 'hF);
    chk("lit_cnt16", int'(instr_count), 20);

    // Asynchronous reset between edges mid-run.
    #2 Reset = 0;
    #1;
    chk("lit_async_pc", int'(pc), 0);
    chk("lit_async_run", int'(running), 0);
    chk("lit_async_cnt", int'(instr_count), 0);
    step();
    Reset = 1;
    step(); step();
    chk("lit_post_reset_idle", int'(running), 0);
    chk("lit_post_reset_pc", int'(pc), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
